// File: rtl/counter_mod_n.sv
// counter_mod_n: parametrised modulo-MOD up/down counter.
//   Modes: wrap (SATURATE=0) emits a one-cycle o_tc on every wrap and counts wraps.
//          saturate (SATURATE=1) holds at the end value; o_tc stays 0.
//   Per-cycle priority: i_clear > i_load > i_en > hold.
//   Cascade: drive the next stage's i_en from this stage's o_tc.
// Ports:
//   clk, reset_n    - clock (rising edge) and asynchronous active-low reset
//   i_en, i_up      - step enable and direction (1 = up)
//   i_clear         - synchronous clear of count and wrap counter
//   i_load          - synchronous load of i_load_val (clamped to MOD-1)
//   o_cnt           - registered count, 0..MOD-1
//   o_tc            - registered wrap tick, high while o_cnt shows the post-wrap value
//   o_at_end        - combinational: count is at the end value for the current i_up
//   o_wrap_cnt      - wraps since reset/clear, modulo 2^WRAP_W
// Legal parameters: MOD >= 2 and MOD <= 2^CNT_W.
module counter_mod_n #(
  parameter int CNT_W    = 7,
  parameter int MOD      = 100,
  parameter int SATURATE = 0,
  parameter int WRAP_W   = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_en,
  input  logic              i_up,
  input  logic              i_clear,
  input  logic              i_load,
  input  logic [CNT_W-1:0]  i_load_val,
  output logic [CNT_W-1:0]  o_cnt,
  output logic              o_tc,
  output logic              o_at_end,
  output logic [WRAP_W-1:0] o_wrap_cnt
);

  // Held as a CNT_W-bit constant so MOD == 2^CNT_W needs no extra bit.
  localparam logic [CNT_W-1:0] END_VAL = CNT_W'(MOD - 1);

  logic [CNT_W-1:0]  cnt_q,  cnt_d;
  logic              tc_q,   tc_d;
  logic [WRAP_W-1:0] wrap_q, wrap_d;

  logic at_top, at_bot;
  assign at_top = (cnt_q == END_VAL);
  assign at_bot = (cnt_q == '0);

  always_comb begin
    cnt_d  = cnt_q;
    tc_d   = 1'b0;
    wrap_d = wrap_q;
    if (i_clear) begin
      cnt_d  = '0;
      wrap_d = '0;
    end else if (i_load) begin
      // Out-of-range loads clamp so o_cnt never leaves 0..MOD-1.
      cnt_d = (i_load_val > END_VAL) ? END_VAL : i_load_val;
    end else if (i_en) begin
      if (i_up) begin
        if (!at_top) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else if (SATURATE == 0) begin
          cnt_d  = '0;
          tc_d   = 1'b1;
          wrap_d = wrap_q + WRAP_W'(1);
        end
      end else begin
        if (!at_bot) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (SATURATE == 0) begin
          cnt_d  = END_VAL;
          tc_d   = 1'b1;
          wrap_d = wrap_q + WRAP_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      tc_q   <= 1'b0;
      wrap_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      tc_q   <= tc_d;
      wrap_q <= wrap_d;
    end
  end

  assign o_cnt      = cnt_q;
  assign o_tc       = tc_q;
  assign o_wrap_cnt = wrap_q;
  // Follows i_up in the same cycle; no dependence on the previous direction.
  assign o_at_end   = i_up ? at_top : at_bot;

endmodule

// File: tb/tb_counter_mod_n.sv
// Scoreboard bench for counter_mod_n. All instances share one set of control
// inputs; each expectation names which instance it checks:
//   0: MOD=100 wrap, 1: MOD=100 saturate, 2: MOD=16 CNT_W=4, 3: two MOD=10 cascaded.
module tb_counter_mod_n;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       en, up, clr, ld;
  logic [6:0] val;

  logic [6:0] a_cnt, s_cnt;
  logic [3:0] h_cnt, c0_cnt, c1_cnt;
  logic       a_tc, s_tc, h_tc, c0_tc, c1_tc;
  logic       a_end, s_end, h_end, c0_end, c1_end;
  logic [7:0] a_wrap, s_wrap, h_wrap, c0_wrap, c1_wrap;

  always #5 clk = ~clk;

  counter_mod_n #(.CNT_W(7), .MOD(100), .SATURATE(0), .WRAP_W(8)) u_a (
    .clk(clk), .reset_n(reset_n), .i_en(en), .i_up(up), .i_clear(clr), .i_load(ld),
    .i_load_val(val), .o_cnt(a_cnt), .o_tc(a_tc), .o_at_end(a_end), .o_wrap_cnt(a_wrap));

  counter_mod_n #(.CNT_W(7), .MOD(100), .SATURATE(1), .WRAP_W(8)) u_s (
    .clk(clk), .reset_n(reset_n), .i_en(en), .i_up(up), .i_clear(clr), .i_load(ld),
    .i_load_val(val), .o_cnt(s_cnt), .o_tc(s_tc), .o_at_end(s_end), .o_wrap_cnt(s_wrap));

  counter_mod_n #(.CNT_W(4), .MOD(16), .SATURATE(0), .WRAP_W(8)) u_h (
    .clk(clk), .reset_n(reset_n), .i_en(en), .i_up(up), .i_clear(clr), .i_load(ld),
    .i_load_val(val[3:0]), .o_cnt(h_cnt), .o_tc(h_tc), .o_at_end(h_end), .o_wrap_cnt(h_wrap));

  counter_mod_n #(.CNT_W(4), .MOD(10), .SATURATE(0), .WRAP_W(8)) u_c0 (
    .clk(clk), .reset_n(reset_n), .i_en(en), .i_up(up), .i_clear(clr), .i_load(ld),
    .i_load_val(val[3:0]), .o_cnt(c0_cnt), .o_tc(c0_tc), .o_at_end(c0_end), .o_wrap_cnt(c0_wrap));

  counter_mod_n #(.CNT_W(4), .MOD(10), .SATURATE(0), .WRAP_W(8)) u_c1 (
    .clk(clk), .reset_n(reset_n), .i_en(c0_tc), .i_up(up), .i_clear(clr), .i_load(ld),
    .i_load_val(val[3:0]), .o_cnt(c1_cnt), .o_tc(c1_tc), .o_at_end(c1_end), .o_wrap_cnt(c1_wrap));

  typedef struct {
    int    sel;
    int    cnt;
    bit    tc;
    int    wrap;
    bit    ae;
    string nm;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  event chk_ev;

  task automatic push(input int sel, input int cnt, input bit tc, input int wrap,
                      input bit ae, input string nm);
    exp_t e;
    e.sel = sel; e.cnt = cnt; e.tc = tc; e.wrap = wrap; e.ae = ae; e.nm = nm;
    q.push_back(e);
  endtask

  // Apply one cycle of inputs; returns just after the rising edge so the
  // caller can push the post-edge expectation.
  task automatic go(input bit e, input bit u, input bit c, input bit l, input int v);
    en = e; up = u; clr = c; ld = l; val = 7'(v);
    @(posedge clk);
  endtask

  // Let the monitor sample at the falling edge before inputs move again.
  task automatic fin();
    @(negedge clk);
    #1;
  endtask

  // Monitor: whenever expectations are pending, compare them against the outputs.
  initial begin
    exp_t e;
    int   ac, aw;
    bit   at, ae;
    forever begin
      @(negedge clk or chk_ev);
      while (q.size() > 0) begin
        e = q.pop_front();
        case (e.sel)
          0:       begin ac = int'(a_cnt); at = a_tc; aw = int'(a_wrap); ae = a_end; end
          1:       begin ac = int'(s_cnt); at = s_tc; aw = int'(s_wrap); ae = s_end; end
          2:       begin ac = int'(h_cnt); at = h_tc; aw = int'(h_wrap); ae = h_end; end
          default: begin
            ac = int'(c1_cnt) * 10 + int'(c0_cnt); at = c1_tc; aw = int'(c1_wrap); ae = c1_end;
          end
        endcase
        n_vec++;
        if (ac != e.cnt || at != e.tc || aw != e.wrap || ae != e.ae) begin
          n_bad++;
          $display("FAIL %s (dut%0d): got cnt=%0d tc=%0d wrap=%0d end=%0d, want cnt=%0d tc=%0d wrap=%0d end=%0d",
                   e.nm, e.sel, ac, at, aw, ae, e.cnt, e.tc, e.wrap, e.ae);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d expectations pending", q.size());
    $fatal(1);
  end

  initial begin
    int d0[4]  = '{1, 0, 99, 98};
    bit dt[4]  = '{0, 0, 1, 0};
    int dw[4]  = '{2, 2, 3, 3};
    bit dae[4] = '{0, 1, 0, 0};
    int ds[4]  = '{1, 0, 0, 0};
    bit dsa[4] = '{0, 1, 1, 1};
    int sc[5]  = '{98, 99, 99, 99, 99};
    bit sae[5] = '{0, 1, 1, 1, 1};
    int ac5[5] = '{98, 99, 0, 1, 2};
    bit at5[5] = '{0, 0, 1, 0, 0};
    int aw5[5] = '{0, 0, 1, 1, 1};
    bit aa5[5] = '{0, 1, 0, 0, 0};

    reset_n = 1'b0; en = 0; up = 1; clr = 0; ld = 0; val = '0;

    // Reset state, checked before any clock edge.
    #2;
    for (int s = 0; s < 4; s++) push(s, 0, 0, 0, 0, "reset");
    -> chk_ev;
    #1;
    @(negedge clk); #1;
    reset_n = 1'b1;

    // Continuous up-count: after step k, cnt = k mod 100, tick on each 99->0.
    for (int k = 1; k <= 205; k++) begin
      go(1, 1, 0, 0, 0);
      push(0, k % 100, (k % 100) == 0, k / 100, (k % 100) == 99, "up100");
      if (k == 15) push(2, 15, 0, 0, 1, "mod16_top");
      if (k == 16 || k == 32) push(2, 0, 1, k / 16, 0, "mod16_wrap");
      if (k == 205) begin
        push(1, 99, 0, 0, 1, "sat_hold_top");
        push(2, 13, 0, 12, 0, "mod16_run");
      end
      fin();
    end

    // Load 2 then count down through the 0 -> 99 wrap.
    go(0, 1, 0, 1, 2);
    push(0, 2, 0, 2, 0, "load2");
    push(1, 2, 0, 0, 0, "sat_load2");
    fin();
    for (int i = 0; i < 4; i++) begin
      go(1, 0, 0, 0, 0);
      push(0, d0[i], dt[i], dw[i], dae[i], "down_wrap");
      push(1, ds[i], 0, 0, dsa[i], "sat_down");
      fin();
    end

    // Load clamp and control priority.
    go(0, 1, 0, 1, 120); push(0, 99, 0, 3, 1, "load_clamp");   fin();
    go(1, 1, 0, 1, 50);  push(0, 50, 0, 3, 0, "load_over_en"); fin();
    go(1, 1, 1, 1, 30);  push(0, 0, 0, 0, 0, "clear_wins");    fin();
    go(0, 1, 0, 1, 99);  push(0, 99, 0, 0, 1, "load99");       fin();
    go(1, 1, 1, 0, 0);   push(0, 0, 0, 0, 0, "clear_at_end");  fin();

    // Saturate from 97 (wrap instance runs alongside).
    go(0, 1, 0, 1, 97);
    push(1, 97, 0, 0, 0, "sat_load97");
    push(0, 97, 0, 0, 0, "load97");
    fin();
    for (int i = 0; i < 5; i++) begin
      go(1, 1, 0, 0, 0);
      push(1, sc[i], 0, 0, sae[i], "sat_up");
      push(0, ac5[i], at5[i], aw5[i], aa5[i], "wrap_up");
      fin();
    end

    // Asynchronous reset between edges while the count is 57.
    go(0, 1, 0, 1, 57); push(0, 57, 0, 1, 0, "load57"); fin();
    #2;
    reset_n = 1'b0;
    #1;
    for (int s = 0; s < 4; s++) push(s, 0, 0, 0, 0, "async_reset");
    -> chk_ev;
    #1;
    @(negedge clk); #1;
    reset_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      go(1, 1, 0, 0, 0); push(0, k, 0, 0, 0, "resume"); fin();
    end

    // Sixteen-state counter at full CNT_W range: wraps both ways without overflow.
    go(1, 1, 1, 0, 0);  push(2, 0, 0, 0, 0, "clr16");   fin();
    go(0, 1, 0, 1, 15); push(2, 15, 0, 0, 1, "load15"); fin();
    go(1, 1, 0, 0, 0);  push(2, 0, 1, 1, 0, "w16_up");  fin();
    go(1, 0, 0, 0, 0);  push(2, 15, 1, 2, 0, "w16_dn"); fin();

    // Cascade: the upper digit steps the cycle after the lower digit's tick,
    // so after k steps upper = ((k-1)/10) mod 10 and lower = k mod 10.
    go(1, 1, 1, 0, 0); push(3, 0, 0, 0, 0, "casc_clr"); fin();
    for (int k = 1; k <= 105; k++) begin
      int hi;
      hi = ((k - 1) / 10) % 10;
      go(1, 1, 0, 0, 0);
      push(3, hi * 10 + (k % 10), k == 101, (k >= 101) ? 1 : 0, hi == 9, "cascade");
      fin();
    end

    @(negedge clk); #1;
    n_vec++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
